// File: rtl/rvfpm_pipe.sv
// Fixed-latency FP move/sign/class unit with its own FP register file.
// In-order pipeline with scoreboard-style RAW stall and no bypass.
module rvfpm_pipe #(
    parameter int FLEN        = 32,
    parameter int EXP_W       = 8,
    parameter int NUM_REGS    = 32,
    parameter int PIPE_STAGES = 3,
    parameter int XLEN        = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [2:0]                  in_op,
    input  logic [$clog2(NUM_REGS)-1:0] in_rd,
    input  logic [$clog2(NUM_REGS)-1:0] in_rs1,
    input  logic [$clog2(NUM_REGS)-1:0] in_rs2,
    input  logic [XLEN-1:0]             in_xdata,
    input  logic [FLEN-1:0]             in_mdata,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [2:0]                  out_op,
    output logic [$clog2(NUM_REGS)-1:0] out_rd,
    output logic [XLEN-1:0]             out_xdata,
    output logic [FLEN-1:0]             out_mdata,
    output logic                        busy
);

    localparam int RW   = $clog2(NUM_REGS);
    localparam int MW   = FLEN - 1 - EXP_W;
    localparam int LAST = PIPE_STAGES - 1;

    localparam logic [2:0] OP_FLW     = 3'd0;
    localparam logic [2:0] OP_FSW     = 3'd1;
    localparam logic [2:0] OP_FMV_X_W = 3'd2;
    localparam logic [2:0] OP_FMV_W_X = 3'd3;
    localparam logic [2:0] OP_FSGNJ   = 3'd4;
    localparam logic [2:0] OP_FSGNJN  = 3'd5;
    localparam logic [2:0] OP_FSGNJX  = 3'd6;
    localparam logic [2:0] OP_FCLASS  = 3'd7;

    function automatic logic writes_rd(input logic [2:0] op);
        return op inside {OP_FLW, OP_FMV_W_X, OP_FSGNJ, OP_FSGNJN, OP_FSGNJX};
    endfunction

    logic [FLEN-1:0]        rf_q [NUM_REGS];
    logic [PIPE_STAGES-1:0] vld_q;
    logic [2:0]             op_q [PIPE_STAGES];
    logic [RW-1:0]          rd_q [PIPE_STAGES];
    logic [XLEN-1:0]        xd_q [PIPE_STAGES];
    logic [FLEN-1:0]        md_q [PIPE_STAGES];
    logic [FLEN-1:0]        wd_q [PIPE_STAGES];

    logic [FLEN-1:0] rs1_v, rs2_v;
    logic [XLEN-1:0] x_d;
    logic [FLEN-1:0] m_d, w_d;
    logic            use1, use2, hazard;
    logic            advance, accept, retire;

    assign rs1_v = rf_q[in_rs1];
    assign rs2_v = rf_q[in_rs2];

    logic             s1;
    logic [EXP_W-1:0] e1;
    logic [MW-1:0]    m1;
    logic             e_max, e_zero, m_zero;
    logic             is_inf, is_nan, is_zero, is_sub, is_norm;
    logic [9:0]       cls;

    assign s1      = rs1_v[FLEN-1];
    assign e1      = rs1_v[FLEN-2 -: EXP_W];
    assign m1      = rs1_v[MW-1:0];
    assign e_max   = &e1;
    assign e_zero  = (e1 == '0);
    assign m_zero  = (m1 == '0);
    assign is_inf  = e_max & m_zero;
    assign is_nan  = e_max & ~m_zero;
    assign is_zero = e_zero & m_zero;
    assign is_sub  = e_zero & ~m_zero;
    assign is_norm = ~e_max & ~e_zero;

    // Bit 0 is -inf, bit 9 is quiet NaN
    assign cls = {is_nan & m1[MW-1], is_nan & ~m1[MW-1],
                  ~s1 & is_inf, ~s1 & is_norm, ~s1 & is_sub,
                  ~s1 & is_zero, s1 & is_zero, s1 & is_sub,
                  s1 & is_norm, s1 & is_inf};

    always_comb begin
        x_d  = '0;
        m_d  = '0;
        w_d  = '0;
        use1 = 1'b0;
        use2 = 1'b0;
        unique case (in_op)
            OP_FLW: w_d = in_mdata;
            OP_FSW: begin
                m_d  = rs2_v;
                use2 = 1'b1;
            end
            OP_FMV_X_W: begin
                x_d  = XLEN'(rs1_v);
                use1 = 1'b1;
            end
            OP_FMV_W_X: w_d = in_xdata[FLEN-1:0];
            OP_FSGNJ: begin
                w_d  = {rs2_v[FLEN-1], rs1_v[FLEN-2:0]};
                use1 = 1'b1;
                use2 = 1'b1;
            end
            OP_FSGNJN: begin
                w_d  = {~rs2_v[FLEN-1], rs1_v[FLEN-2:0]};
                use1 = 1'b1;
                use2 = 1'b1;
            end
            OP_FSGNJX: begin
                w_d  = {rs1_v[FLEN-1] ^ rs2_v[FLEN-1], rs1_v[FLEN-2:0]};
                use1 = 1'b1;
                use2 = 1'b1;
            end
            OP_FCLASS: begin
                x_d  = XLEN'(cls);
                use1 = 1'b1;
            end
        endcase
    end

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < PIPE_STAGES; i++) begin
            if (vld_q[i] && writes_rd(op_q[i]) &&
                ((use1 && rd_q[i] == in_rs1) ||
                 (use2 && rd_q[i] == in_rs2)))
                hazard = 1'b1;
        end
    end

    assign advance  = !(vld_q[LAST] && !out_ready);
    assign in_ready = advance && !hazard;
    assign accept   = in_valid && in_ready;
    assign retire   = vld_q[LAST] && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            for (int i = 0; i < PIPE_STAGES; i++) begin
                op_q[i] <= '0;
                rd_q[i] <= '0;
                xd_q[i] <= '0;
                md_q[i] <= '0;
                wd_q[i] <= '0;
            end
            for (int r = 0; r < NUM_REGS; r++)
                rf_q[r] <= '0;
        end else begin
            if (retire && writes_rd(op_q[LAST]))
                rf_q[rd_q[LAST]] <= wd_q[LAST];
            if (advance) begin
                // Bubbles carry zero payload so idle outputs read zero
                vld_q[0] <= accept;
                op_q[0]  <= accept ? in_op : '0;
                rd_q[0]  <= accept ? in_rd : '0;
                xd_q[0]  <= accept ? x_d : '0;
                md_q[0]  <= accept ? m_d : '0;
                wd_q[0]  <= accept ? w_d : '0;
                for (int i = 1; i < PIPE_STAGES; i++) begin
                    vld_q[i] <= vld_q[i-1];
                    op_q[i]  <= op_q[i-1];
                    rd_q[i]  <= rd_q[i-1];
                    xd_q[i]  <= xd_q[i-1];
                    md_q[i]  <= md_q[i-1];
                    wd_q[i]  <= wd_q[i-1];
                end
            end
        end
    end

    assign out_valid = vld_q[LAST];
    assign out_op    = op_q[LAST];
    assign out_rd    = rd_q[LAST];
    assign out_xdata = xd_q[LAST];
    assign out_mdata = md_q[LAST];
    assign busy      = |vld_q;

endmodule
